// File: rtl/dsp_sop_lane_scheduler.sv
// Round-robin scheduler that shares one SOP lane between NREQ requesters and routes
// results back by tag, with a per-requester cap on in-flight issues.
module dsp_sop_lane_scheduler #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned IDW    = $clog2(NREQ),
    parameter int unsigned DP_LAT = 2,
    parameter int unsigned MAXOUT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hold,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*148-1:0]   req_data,
    output logic [147:0]          dp_inp,
    input  logic [36:0]           dp_outp,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [36:0]           rsp_data,
    output logic                  busy
);

    localparam int unsigned CW = $clog2(MAXOUT + 1);

    logic [CW-1:0]   cnt_q [NREQ];
    logic [CW-1:0]   cnt_d [NREQ];
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [DP_LAT:0] tag_vld_q, tag_vld_d;
    logic [IDW-1:0]  tag_id_q [DP_LAT+1];
    logic [IDW-1:0]  tag_id_d [DP_LAT+1];
    logic [147:0]    dp_inp_q, dp_inp_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [36:0]     rsp_data_q, rsp_data_d;

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] inc_vec, dec_vec;
    logic            gnt_vld;
    logic [IDW-1:0]  gnt_id;
    logic [IDW:0]    scan_idx;
    logic            retire;
    logic [IDW-1:0]  retire_id;
    logic            any_cnt;

    // Eligibility looks only at the registered count; a same-cycle retire does not help.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            eligible[i] = req_valid[i] && (cnt_q[i] < CW'(MAXOUT));
        end
    end

    always_comb begin
        gnt_vld  = 1'b0;
        gnt_id   = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = {1'b0, ptr_q} + (IDW+1)'(k);
            if (scan_idx >= (IDW+1)'(NREQ)) begin
                scan_idx = scan_idx - (IDW+1)'(NREQ);
            end
            if (!gnt_vld && eligible[scan_idx[IDW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_id  = scan_idx[IDW-1:0];
            end
        end
        if (hold) begin
            gnt_vld = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_ready[i] = gnt_vld && (gnt_id == IDW'(i));
        end
    end

    assign retire    = tag_vld_q[DP_LAT];
    assign retire_id = tag_id_q[DP_LAT];

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld) begin
            ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
        end

        dp_inp_d = dp_inp_q;
        if (gnt_vld) begin
            dp_inp_d = req_data[32'(gnt_id) * 148 +: 148];
        end

        tag_vld_d   = {tag_vld_q[DP_LAT-1:0], gnt_vld};
        tag_id_d[0] = gnt_id;
        for (int unsigned k = 1; k <= DP_LAT; k++) begin
            tag_id_d[k] = tag_id_q[k-1];
        end

        rsp_valid_d = retire;
        rsp_id_d    = retire ? retire_id : rsp_id_q;
        rsp_data_d  = retire ? dp_outp : rsp_data_q;
    end

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            inc_vec[i] = gnt_vld && (gnt_id == IDW'(i));
            dec_vec[i] = retire && (retire_id == IDW'(i));
            cnt_d[i]   = cnt_q[i];
            if (inc_vec[i] && !dec_vec[i]) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else if (dec_vec[i] && !inc_vec[i]) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end
        end
    end

    // The response register counts as busy so busy drops only after the last rsp_valid.
    always_comb begin
        any_cnt = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (cnt_q[i] != '0) begin
                any_cnt = 1'b1;
            end
        end
    end

    assign busy = (|tag_vld_q) || any_cnt || rsp_valid_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q       <= '0;
            tag_vld_q   <= '0;
            dp_inp_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            for (int unsigned i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
            end
            for (int unsigned k = 0; k <= DP_LAT; k++) begin
                tag_id_q[k] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            tag_vld_q   <= tag_vld_d;
            dp_inp_q    <= dp_inp_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            for (int unsigned i = 0; i < NREQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            for (int unsigned k = 0; k <= DP_LAT; k++) begin
                tag_id_q[k] <= tag_id_d[k];
            end
        end
    end

    assign dp_inp    = dp_inp_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_dsp_sop_lane_scheduler.sv
// Bench for dsp_sop_lane_scheduler: a behavioural lane drives dp_outp, and a queue of
// pending responses predicts grants, credits and response timing.
module tb_dsp_sop_lane_scheduler;

    localparam int NREQ   = 4;
    localparam int IDW    = 2;
    localparam int DP_LAT = 2;
    localparam int MAXOUT = 2;

    typedef struct {
        int             due;
        logic [IDW-1:0] id;
        logic [36:0]    res;
    } pend_t;

    logic                clk;
    logic                drv_reset;
    logic                drv_hold;
    logic [NREQ-1:0]     drv_valid;
    logic [NREQ*148-1:0] drv_data;
    logic [NREQ-1:0]     req_ready;
    logic [147:0]        dp_inp;
    logic [36:0]         dp_outp;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [36:0]         rsp_data;
    logic                busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    pend_t          pq[$];
    int             m_ptr = 0;
    logic [147:0]   exp_dp = '0;
    logic           exp_rsp_valid = 1'b0;
    logic [IDW-1:0] exp_rsp_id = '0;
    logic [36:0]    exp_rsp_data = '0;

    dsp_sop_lane_scheduler #(
        .NREQ   (NREQ),
        .IDW    (IDW),
        .DP_LAT (DP_LAT),
        .MAXOUT (MAXOUT)
    ) dut (
        .clk       (clk),
        .reset     (drv_reset),
        .hold      (drv_hold),
        .req_valid (drv_valid),
        .req_ready (req_ready),
        .req_data  (drv_data),
        .dp_inp    (dp_inp),
        .dp_outp   (dp_outp),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [36:0] lane_f(input logic [147:0] d);
        logic [73:0] p;
        p = 74'(d[36:0]) * 74'(d[73:37]) + 74'(d[110:74]) * 74'(d[147:111]);
        return p[36:0];
    endfunction

    // Behavioural lane: result of dp_inp appears DP_LAT cycles after dp_inp changes.
    logic [36:0] lane_q [DP_LAT];
    always @(posedge clk) begin
        lane_q[0] <= lane_f(dp_inp);
        for (int k = 1; k < DP_LAT; k++) lane_q[k] <= lane_q[k-1];
    end
    assign dp_outp = lane_q[DP_LAT-1];

    function automatic logic [NREQ*148-1:0] rand_data();
        logic [NREQ*148-1:0] d;
        logic [159:0] w;
        for (int i = 0; i < NREQ; i++) begin
            w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            d[i*148 +: 148] = w[147:0];
        end
        return d;
    endfunction

    function automatic int model_count(input int id);
        int n = 0;
        foreach (pq[k]) if (int'(pq[k].id) == id) n++;
        return n;
    endfunction

    function automatic int model_grant();
        int idx;
        if (drv_hold) return -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (drv_valid[idx] && model_count(idx) < MAXOUT) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] model_ready();
        int g;
        logic [NREQ-1:0] r;
        g = model_grant();
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // Advance the model across one rising edge, then step the clock.
    task automatic tick();
        int    g;
        pend_t e;
        g = model_grant();
        if (!drv_reset) begin
            pq.delete();
            m_ptr         = 0;
            exp_dp        = '0;
            exp_rsp_valid = 1'b0;
            exp_rsp_id    = '0;
            exp_rsp_data  = '0;
        end else begin
            exp_rsp_valid = 1'b0;
            if (pq.size() > 0 && pq[0].due == cyc + 1) begin
                e             = pq.pop_front();
                exp_rsp_valid = 1'b1;
                exp_rsp_id    = e.id;
                exp_rsp_data  = e.res;
            end
            if (g >= 0) begin
                e.due  = cyc + DP_LAT + 2;
                e.id   = IDW'(g);
                e.res  = lane_f(drv_data[g*148 +: 148]);
                pq.push_back(e);
                exp_dp = drv_data[g*148 +: 148];
                m_ptr  = (g + 1) % NREQ;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drv_reset = 1'b0;
        drv_hold  = 1'b0;
        drv_valid = '0;
        drv_data  = rand_data();
        tick();
        tick();
        drv_reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_checks++;
        if (rsp_id !== '0) begin n_fail++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
        n_checks++;
        if (rsp_data !== '0) begin n_fail++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
        n_checks++;
        if (dp_inp !== '0) begin n_fail++; $display("FAIL reset_dp_inp got %h want 0", dp_inp); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++;
        if (req_ready !== '0) begin n_fail++; $display("FAIL reset_ready got %b want 0", req_ready); end
        tick();
    endtask

    task automatic test_single();
        int hs_cyc;
        int n_rsp = 0;
        drv_valid          = 4'b0001;
        drv_data           = rand_data();
        drv_data[147:0]    = 148'h1;
        @(negedge clk);
        hs_cyc = cyc;
        n_checks++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready got %b want 0001", req_ready); end
        tick();
        drv_valid = '0;
        @(negedge clk);
        n_checks++;
        if (dp_inp !== 148'h1) begin n_fail++; $display("FAIL single_dp_inp got %h want 1", dp_inp); end
        tick();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== exp_rsp_valid) begin
                n_fail++; $display("FAIL single_rsp_valid cyc %0d got %b want %b", cyc, rsp_valid, exp_rsp_valid);
            end
            if (rsp_valid === 1'b1) begin
                n_rsp++;
                n_checks++;
                if (cyc != hs_cyc + DP_LAT + 2 || rsp_id !== 2'd0 || rsp_data !== exp_rsp_data) begin
                    n_fail++;
                    $display("FAIL single_rsp cyc %0d id %0d data %h want cyc %0d id 0 data %h",
                             cyc, rsp_id, rsp_data, hs_cyc + DP_LAT + 2, exp_rsp_data);
                end
            end
            tick();
        end
        n_checks++;
        if (n_rsp != 1) begin n_fail++; $display("FAIL single_rsp_count got %0d want 1", n_rsp); end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] want;
        drv_reset = 1'b0;
        drv_valid = '0;
        tick();
        drv_reset = 1'b1;
        for (int i = 0; i < 22; i++) begin
            drv_valid = (i < 16) ? 4'b1111 : 4'b0000;
            drv_data  = rand_data();
            @(negedge clk);
            want = (i < 16) ? NREQ'(1 << (i % NREQ)) : '0;
            n_checks++;
            if (req_ready !== want) begin n_fail++; $display("FAIL rr_ready cyc %0d got %b want %b", i, req_ready, want); end
            n_checks++;
            if (rsp_valid !== exp_rsp_valid ||
                (exp_rsp_valid && (rsp_id !== exp_rsp_id || rsp_data !== exp_rsp_data))) begin
                n_fail++;
                $display("FAIL rr_rsp cyc %0d got v%b id%0d %h want v%b id%0d %h", i, rsp_valid, rsp_id,
                         rsp_data, exp_rsp_valid, exp_rsp_id, exp_rsp_data);
            end
            tick();
        end
    endtask

    task automatic test_credit_limit();
        logic [NREQ-1:0] want;
        for (int i = 0; i < 22; i++) begin
            drv_valid = (i < 16) ? 4'b0100 : 4'b0000;
            drv_data  = rand_data();
            @(negedge clk);
            want = (i < 16 && (i % 4) < 2) ? 4'b0100 : 4'b0000;
            n_checks++;
            if (req_ready !== want) begin n_fail++; $display("FAIL credit_ready cyc %0d got %b want %b", i, req_ready, want); end
            n_checks++;
            if (rsp_valid !== exp_rsp_valid ||
                (exp_rsp_valid && (rsp_id !== exp_rsp_id || rsp_data !== exp_rsp_data))) begin
                n_fail++;
                $display("FAIL credit_rsp cyc %0d got v%b id%0d %h want v%b id%0d %h", i, rsp_valid, rsp_id,
                         rsp_data, exp_rsp_valid, exp_rsp_id, exp_rsp_data);
            end
            tick();
        end
    endtask

    task automatic test_hold_drain();
        int n_rsp = 0;
        for (int i = 0; i < 12; i++) begin
            drv_valid = 4'b1111;
            drv_hold  = (i >= 3);
            drv_data  = rand_data();
            @(negedge clk);
            n_checks++;
            if (req_ready !== model_ready()) begin
                n_fail++; $display("FAIL hold_ready cyc %0d got %b want %b", i, req_ready, model_ready());
            end
            if (i >= 3) begin
                n_checks++;
                if (req_ready !== '0) begin n_fail++; $display("FAIL hold_no_grant cyc %0d got %b want 0", i, req_ready); end
                if (rsp_valid === 1'b1) n_rsp++;
            end
            n_checks++;
            if (rsp_valid !== exp_rsp_valid ||
                (exp_rsp_valid && (rsp_id !== exp_rsp_id || rsp_data !== exp_rsp_data))) begin
                n_fail++;
                $display("FAIL hold_rsp cyc %0d got v%b id%0d %h want v%b id%0d %h", i, rsp_valid, rsp_id,
                         rsp_data, exp_rsp_valid, exp_rsp_id, exp_rsp_data);
            end
            if (pq.size() > 0) begin
                n_checks++;
                if (busy !== 1'b1) begin n_fail++; $display("FAIL hold_busy cyc %0d got %b want 1", i, busy); end
            end else if (!exp_rsp_valid) begin
                n_checks++;
                if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_idle cyc %0d got %b want 0", i, busy); end
            end
            tick();
        end
        drv_hold  = 1'b0;
        drv_valid = '0;
        n_checks++;
        if (n_rsp != 3) begin n_fail++; $display("FAIL hold_rsp_count got %0d want 3", n_rsp); end
    endtask

    task automatic test_reset_inflight();
        for (int i = 0; i < 2; i++) begin
            drv_valid = 4'b0011;
            drv_data  = rand_data();
            @(negedge clk);
            n_checks++;
            if (req_ready !== model_ready()) begin
                n_fail++; $display("FAIL rst_fl_ready cyc %0d got %b want %b", i, req_ready, model_ready());
            end
            tick();
        end
        drv_valid = '0;
        drv_reset = 1'b0;
        tick();
        drv_reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL rst_fl_quiet cyc %0d got v%b busy%b want 0 0", i, rsp_valid, busy);
            end
            tick();
        end
        drv_valid = 4'b1010;
        drv_data  = rand_data();
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rst_fl_first_grant got %b want 0010", req_ready); end
        tick();
        drv_valid = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== exp_rsp_valid ||
                (exp_rsp_valid && (rsp_id !== exp_rsp_id || rsp_data !== exp_rsp_data))) begin
                n_fail++;
                $display("FAIL rst_fl_rsp cyc %0d got v%b id%0d %h want v%b id%0d %h", i, rsp_valid, rsp_id,
                         rsp_data, exp_rsp_valid, exp_rsp_id, exp_rsp_data);
            end
            tick();
        end
    endtask

    task automatic test_simul_credit();
        logic [13:0] pat;
        pat = 14'b00000011111001;
        for (int i = 0; i < 14; i++) begin
            drv_valid = pat[i] ? 4'b0010 : 4'b0000;
            drv_data  = rand_data();
            @(negedge clk);
            n_checks++;
            if (req_ready !== model_ready()) begin
                n_fail++; $display("FAIL simul_ready cyc %0d got %b want %b", i, req_ready, model_ready());
            end
            // Cycle 3 issues as a response retires; the count must stay below the cap.
            if (i == 4 || i == 5) begin
                n_checks++;
                if (req_ready !== ((i == 4) ? 4'b0010 : 4'b0000)) begin
                    n_fail++; $display("FAIL simul_credit cyc %0d got %b want %b", i, req_ready,
                                       (i == 4) ? 4'b0010 : 4'b0000);
                end
            end
            n_checks++;
            if (rsp_valid !== exp_rsp_valid ||
                (exp_rsp_valid && (rsp_id !== exp_rsp_id || rsp_data !== exp_rsp_data))) begin
                n_fail++;
                $display("FAIL simul_rsp cyc %0d got v%b id%0d %h want v%b id%0d %h", i, rsp_valid, rsp_id,
                         rsp_data, exp_rsp_valid, exp_rsp_id, exp_rsp_data);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 410; i++) begin
            drv_valid = (i < 400) ? NREQ'($urandom()) : '0;
            drv_hold  = (i < 400) && ($urandom_range(0, 7) == 0);
            drv_data  = rand_data();
            @(negedge clk);
            n_checks++;
            if (req_ready !== model_ready()) begin
                n_fail++; $display("FAIL rand_ready cyc %0d got %b want %b", i, req_ready, model_ready());
            end
            n_checks++;
            if (rsp_valid !== exp_rsp_valid ||
                (exp_rsp_valid && (rsp_id !== exp_rsp_id || rsp_data !== exp_rsp_data))) begin
                n_fail++;
                $display("FAIL rand_rsp cyc %0d got v%b id%0d %h want v%b id%0d %h", i, rsp_valid, rsp_id,
                         rsp_data, exp_rsp_valid, exp_rsp_id, exp_rsp_data);
            end
            n_checks++;
            if (dp_inp !== exp_dp) begin n_fail++; $display("FAIL rand_dp_inp cyc %0d got %h want %h", i, dp_inp, exp_dp); end
            if (pq.size() > 0) begin
                n_checks++;
                if (busy !== 1'b1) begin n_fail++; $display("FAIL rand_busy cyc %0d got %b want 1", i, busy); end
            end else if (!exp_rsp_valid) begin
                n_checks++;
                if (busy !== 1'b0) begin n_fail++; $display("FAIL rand_idle cyc %0d got %b want 0", i, busy); end
            end
            tick();
        end
        drv_hold = 1'b0;
    endtask

    initial begin
        drv_reset = 1'b0;
        drv_hold  = 1'b0;
        drv_valid = '0;
        drv_data  = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_credit_limit();
        test_hold_drain();
        test_reset_inflight();
        test_simul_credit();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
